// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad front end.
package microwave_pkg;

    // Width of one BCD digit and number of digits in the MM:SS display.
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 4;

    // Default number of consecutive high samples of valid before a key is taken.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 2;

    // Key debounce FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StHeld = 2'd2
    } key_state_e;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debounce FSM: turns a held valid level into a single accept strobe.
module key_debounce
    import microwave_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enablen,
    input  logic i_clear,
    input  logic i_valid,
    output logic o_accept
);

    localparam logic [3:0] CntTarget = 4'(DEBOUNCE_CYCLES);

    key_state_e r_state;
    key_state_e w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    // Set when clear lands while a key is held; that key must be released
    // before anything new is debounced, so a clear never re-enters its digit.
    logic       r_lock;
    logic       w_lock_nxt;

    // State, debounce count and post-clear lockout registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // Next-state and accept strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lock_nxt  = r_lock;
        o_accept    = 1'b0;

        if (i_enablen) begin
            // Disabled: drop any press in progress; lockout is kept as is.
            w_state_nxt = StIdle;
            w_cnt_nxt   = 4'd0;
        end else if (i_clear) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 4'd0;
            w_lock_nxt  = i_valid;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!i_valid) begin
                        w_lock_nxt = 1'b0;
                    end else if (!r_lock) begin
                        if (CntTarget == 4'd1) begin
                            o_accept    = 1'b1;
                            w_state_nxt = StHeld;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = StArm;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                StArm: begin
                    if (!i_valid) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = 4'd0;
                    end else if (r_cnt + 4'd1 == CntTarget) begin
                        o_accept    = 1'b1;
                        w_state_nxt = StHeld;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                StHeld: begin
                    // Digit changes while held are ignored until release.
                    if (!i_valid) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/digit_loader.sv
// MM:SS time entry: debounced keypad digits shift in from the right.
module digit_loader
    import microwave_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enablen,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [BCD_W-1:0] i_bcd,
    output logic [BCD_W-1:0] o_min_tens,
    output logic [BCD_W-1:0] o_min_ones,
    output logic [BCD_W-1:0] o_sec_tens,
    output logic [BCD_W-1:0] o_sec_ones,
    output logic [2:0]       o_digit_count,
    output logic             o_full,
    output logic             o_nonzero,
    output logic             o_accepted
);

    localparam logic [2:0] CountMax = 3'(MAX_DIGITS);

    logic [BCD_W-1:0] r_min_tens;
    logic [BCD_W-1:0] r_min_ones;
    logic [BCD_W-1:0] r_sec_tens;
    logic [BCD_W-1:0] r_sec_ones;
    logic [2:0]       r_count;
    logic             r_accepted;

    logic w_accept;
    logic w_full;
    logic w_shift;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enablen(i_enablen),
        .i_clear  (i_clear),
        .i_valid  (i_valid),
        .o_accept (w_accept)
    );

    // A debounced key only loads when it is a decimal digit and there is room.
    always_comb begin
        w_full  = (r_count == CountMax);
        w_shift = w_accept && is_bcd(i_bcd) && !w_full;
    end

    // Digit shift register, digit count and accepted pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_count    <= 3'd0;
            r_accepted <= 1'b0;
        end else if (i_enablen) begin
            r_accepted <= 1'b0;
        end else if (i_clear) begin
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_count    <= 3'd0;
            r_accepted <= 1'b0;
        end else begin
            r_accepted <= w_shift;
            if (w_shift) begin
                r_min_tens <= r_min_ones;
                r_min_ones <= r_sec_tens;
                r_sec_tens <= r_sec_ones;
                r_sec_ones <= i_bcd;
                r_count    <= r_count + 3'd1;
            end
        end
    end

    // Output drive; full and nonzero decode straight from the registers.
    always_comb begin
        o_min_tens    = r_min_tens;
        o_min_ones    = r_min_ones;
        o_sec_tens    = r_sec_tens;
        o_sec_ones    = r_sec_ones;
        o_digit_count = r_count;
        o_accepted    = r_accepted;
        o_full        = w_full;
        o_nonzero     = (r_min_tens != '0) || (r_min_ones != '0) ||
                        (r_sec_tens != '0) || (r_sec_ones != '0);
    end

endmodule

// File: tb/tb_digit_loader.sv
// Self-checking bench for digit_loader with a press-level reference model.
module tb_digit_loader;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enablen = 1'b0;
    logic       clear = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] bcd = 4'd0;

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] digit_count;
    logic       full, nonzero, accepted;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    bit chk_en   = 1'b0;

    digit_loader #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enablen    (enablen),
        .i_clear      (clear),
        .i_valid      (valid),
        .i_bcd        (bcd),
        .o_min_tens   (min_tens),
        .o_min_ones   (min_ones),
        .o_sec_tens   (sec_tens),
        .o_sec_ones   (sec_ones),
        .o_digit_count(digit_count),
        .o_full       (full),
        .o_nonzero    (nonzero),
        .o_accepted   (accepted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: digits as a list of entered values, presses tracked as
    // the length of the current run of enabled high samples.
    int m_dig[4] = '{0, 0, 0, 0};
    int m_count  = 0;
    bit m_acc    = 1'b0;
    int m_run    = 0;
    bit m_done   = 1'b0;
    bit m_lock   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dig   = '{0, 0, 0, 0};
            m_count = 0;
            m_acc   = 1'b0;
            m_run   = 0;
            m_done  = 1'b0;
            m_lock  = 1'b0;
        end else if (enablen) begin
            m_acc  = 1'b0;
            m_run  = 0;
            m_done = 1'b0;
        end else if (clear) begin
            m_dig   = '{0, 0, 0, 0};
            m_count = 0;
            m_acc   = 1'b0;
            m_run   = 0;
            m_done  = 1'b0;
            m_lock  = valid;
        end else begin
            m_acc = 1'b0;
            if (!valid) begin
                m_run  = 0;
                m_done = 1'b0;
                m_lock = 1'b0;
            end else if (!m_lock && !m_done) begin
                m_run++;
                if (m_run == N) begin
                    m_done = 1'b1;
                    if (int'(bcd) <= 9 && m_count < 4) begin
                        for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i+1];
                        m_dig[3] = int'(bcd);
                        m_count++;
                        m_acc = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (accepted) n_pulses++;
        if (chk_en) begin
            check("min_tens", int'(min_tens), m_dig[0]);
            check("min_ones", int'(min_ones), m_dig[1]);
            check("sec_tens", int'(sec_tens), m_dig[2]);
            check("sec_ones", int'(sec_ones), m_dig[3]);
            check("digit_count", int'(digit_count), m_count);
            check("full", int'(full), int'(m_count == 4));
            check("nonzero", int'(nonzero),
                  int'(m_dig[0] != 0 || m_dig[1] != 0 || m_dig[2] != 0 || m_dig[3] != 0));
            check("accepted", int'(accepted), int'(m_acc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        valid = 1'b1;
        bcd   = 4'(d);
        repeat (5) tick();
        valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int p0;

    initial begin
        #1;
        do_reset();
        chk_en = 1'b1;
        #4;
        check("reset_count", int'(digit_count), 0);
        check("reset_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
        check("reset_full", int'(full), 0);
        check("reset_nonzero", int'(nonzero), 0);
        check("reset_accepted", int'(accepted), 0);
        tick();

        // One-cycle glitch must not load anything.
        p0 = n_pulses;
        valid = 1'b1;
        bcd   = 4'd7;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        check("glitch_count", int'(digit_count), 0);
        check("glitch_sec_ones", int'(sec_ones), 0);
        check("glitch_pulses", n_pulses - p0, 0);

        // Sequence 1,2,3,0 with latency probe on the first press.
        p0 = n_pulses;
        valid = 1'b1;
        bcd   = 4'd1;
        tick();
        check("latency_edge_k", int'(accepted), 0);
        tick();
        check("latency_edge_k1", int'(accepted), 1);
        check("latency_sec_ones", int'(sec_ones), 1);
        repeat (3) tick();
        valid = 1'b0;
        repeat (3) tick();
        press(2);
        press(3);
        press(0);
        check("seq_min_tens", int'(min_tens), 1);
        check("seq_min_ones", int'(min_ones), 2);
        check("seq_sec_tens", int'(sec_tens), 3);
        check("seq_sec_ones", int'(sec_ones), 0);
        check("seq_count", int'(digit_count), 4);
        check("seq_full", int'(full), 1);
        check("seq_pulses", n_pulses - p0, 4);

        // Non-decimal key, then overflow past four digits.
        do_reset();
        p0 = n_pulses;
        press(12);
        check("badbcd_count", int'(digit_count), 0);
        check("badbcd_pulses", n_pulses - p0, 0);
        press(9);
        press(9);
        press(9);
        press(9);
        press(4);
        check("ovf_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h9999);
        check("ovf_count", int'(digit_count), 4);
        check("ovf_pulses", n_pulses - p0, 4);

        // Clear while a key is held; that key needs release and re-press.
        do_reset();
        press(4);
        valid = 1'b1;
        bcd   = 4'd5;
        repeat (3) tick();
        bcd = 4'd3;
        tick();
        check("preclr_count", int'(digit_count), 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        check("clr_count", int'(digit_count), 0);
        check("clr_nonzero", int'(nonzero), 0);
        check("clr_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
        valid = 1'b0;
        repeat (2) tick();
        press(5);
        check("repress_count", int'(digit_count), 1);
        check("repress_sec_ones", int'(sec_ones), 5);

        // Reset in the middle of a debounce with the key still held.
        valid = 1'b1;
        bcd   = 4'd8;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_first_edge_acc", int'(accepted), 0);
        check("rst_first_edge_cnt", int'(digit_count), 0);
        tick();
        check("rst_accept", int'(accepted), 1);
        check("rst_count", int'(digit_count), 1);
        check("rst_sec_ones", int'(sec_ones), 8);
        valid = 1'b0;
        repeat (3) tick();

        // Disabled while pressing, then enabled with the key still held.
        p0 = n_pulses;
        enablen = 1'b1;
        valid   = 1'b1;
        bcd     = 4'd6;
        repeat (4) tick();
        check("dis_count", int'(digit_count), 1);
        check("dis_pulses", n_pulses - p0, 0);
        enablen = 1'b0;
        tick();
        check("en_first_edge", int'(accepted), 0);
        tick();
        check("en_accept", int'(accepted), 1);
        check("en_sec_ones", int'(sec_ones), 6);
        check("en_sec_tens", int'(sec_tens), 8);
        check("en_count", int'(digit_count), 2);
        valid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
